// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: datapath widths, the hard-wired zero register
// index and the values the WB register stage holds while in reset.
package pipeline_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  localparam logic              RST_EN   = 1'b0;
  localparam logic [ADDR_W-1:0] RST_ADDR = '0;
  localparam logic [DATA_W-1:0] RST_DATA = '0;

endpackage

// File: rtl/wb_pipe_reg.sv
// Parameterised pipeline register with asynchronous, active-high reset to a
// fixed value; used for the {en, addr, data} write-back bundle.
module wb_pipe_reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= RESET_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/writeback.sv
// WB stage: registers the MEM/WB result onto the register-file write port and
// mirrors it combinationally to forwarding. Option macro: WB_ZERO_REG_GUARD_EN.
module writeback
  import pipeline_pkg::*;
#(
  parameter int DATA_W = pipeline_pkg::DATA_W,
  parameter int ADDR_W = pipeline_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] mem_wb_regdest,
  input  logic              mem_wb_writereg,
  input  logic [DATA_W-1:0] mem_wb_wbvalue,
  output logic              wb_reg_en,
  output logic [ADDR_W-1:0] wb_reg_addr,
  output logic [DATA_W-1:0] wb_reg_data,
  output logic [DATA_W-1:0] wb_fw_wbvalue,
  output logic              wb_fw_writereg
);

  localparam int BUNDLE_W = 1 + ADDR_W + DATA_W;
  localparam logic [BUNDLE_W-1:0] RST_BUNDLE =
    {RST_EN, ADDR_W'(RST_ADDR), DATA_W'(RST_DATA)};

  logic                write_ok;
  logic [BUNDLE_W-1:0] bundle_d;
  logic [BUNDLE_W-1:0] bundle_q;

`ifdef WB_ZERO_REG_GUARD_EN
  // r0 is never written; the same qualified enable feeds forwarding so a
  // younger instruction never forwards a value destined for r0.
  assign write_ok = mem_wb_writereg && (mem_wb_regdest != ADDR_W'(REG_ZERO));
`else
  assign write_ok = mem_wb_writereg;
`endif

  // Forwarding bypasses the register entirely and ignores reset.
  assign wb_fw_wbvalue  = mem_wb_wbvalue;
  assign wb_fw_writereg = write_ok;

  // Address and data travel unconditionally; only the enable qualifies a write.
  assign bundle_d = {write_ok, mem_wb_regdest, mem_wb_wbvalue};

  wb_pipe_reg #(
    .WIDTH     (BUNDLE_W),
    .RESET_VAL (RST_BUNDLE)
  ) u_wb_pipe_reg (
    .clock (clock),
    .reset (reset),
    .d     (bundle_d),
    .q     (bundle_q)
  );

  assign {wb_reg_en, wb_reg_addr, wb_reg_data} = bundle_q;

endmodule

// File: tb/tb_writeback.sv
// Scoreboard bench for writeback: stimulus pushes the expected registered
// bundle per cycle, a monitor pops and compares one cycle later.
module tb_writeback;

  typedef struct packed {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_exp_t;

  logic        clock;
  logic        reset;
  logic [4:0]  mem_wb_regdest;
  logic        mem_wb_writereg;
  logic [31:0] mem_wb_wbvalue;
  logic        wb_reg_en;
  logic [4:0]  wb_reg_addr;
  logic [31:0] wb_reg_data;
  logic [31:0] wb_fw_wbvalue;
  logic        wb_fw_writereg;

  int errors = 0;
  int checks = 0;
  wb_exp_t exp_q[$];

  writeback dut (
    .clock           (clock),
    .reset           (reset),
    .mem_wb_regdest  (mem_wb_regdest),
    .mem_wb_writereg (mem_wb_writereg),
    .mem_wb_wbvalue  (mem_wb_wbvalue),
    .wb_reg_en       (wb_reg_en),
    .wb_reg_addr     (wb_reg_addr),
    .wb_reg_data     (wb_reg_data),
    .wb_fw_wbvalue   (wb_fw_wbvalue),
    .wb_fw_writereg  (wb_fw_writereg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Expected enable: the writereg flag, suppressed for r0 when the guard is built in.
  function automatic logic model_en(input logic [4:0] dest, input logic wr);
`ifdef WB_ZERO_REG_GUARD_EN
    return wr && (dest != 5'd0);
`else
    return wr;
`endif
  endfunction

  // Drive one vector now (caller aligns to the falling edge), queue the
  // expected register contents and check the forwarding path after settling.
  task automatic drive(input logic [4:0] dest, input logic wr, input logic [31:0] val,
                       input logic fw_en_req);
    wb_exp_t e;
    mem_wb_regdest  = dest;
    mem_wb_writereg = wr;
    mem_wb_wbvalue  = val;
    e.en   = model_en(dest, wr);
    e.addr = dest;
    e.data = val;
    exp_q.push_back(e);
    #1;
    chk("fw_wbvalue", wb_fw_wbvalue, val);
    chk("fw_writereg", {31'd0, wb_fw_writereg}, {31'd0, fw_en_req});
  endtask

  // Monitor: the register port presents a new result every cycle.
  initial begin
    wb_exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("wb: en=%0b addr=%0d data=%h (expect en=%0b addr=%0d data=%h)",
                 wb_reg_en, wb_reg_addr, wb_reg_data, e.en, e.addr, e.data);
        chk("reg_en", {31'd0, wb_reg_en}, {31'd0, e.en});
        chk("reg_addr", {27'd0, wb_reg_addr}, {27'd0, e.addr});
        chk("reg_data", wb_reg_data, e.data);
      end
    end
  end

  initial begin
    logic zero_en_req;
`ifdef WB_ZERO_REG_GUARD_EN
    zero_en_req = 1'b0;
`else
    zero_en_req = 1'b1;
`endif
    reset = 1'b0;
    mem_wb_regdest = '0;
    mem_wb_writereg = 1'b0;
    mem_wb_wbvalue = '0;

    // Reset takes effect with no clock edge; forwarding still follows inputs.
    #2;
    reset = 1'b1;
    mem_wb_regdest = 5'd9;
    mem_wb_writereg = 1'b1;
    mem_wb_wbvalue = 32'hCAFE0001;
    #1;
    chk("rst_en", {31'd0, wb_reg_en}, 32'd0);
    chk("rst_addr", {27'd0, wb_reg_addr}, 32'd0);
    chk("rst_data", wb_reg_data, 32'd0);
    chk("rst_fw_val", wb_fw_wbvalue, 32'hCAFE0001);
    chk("rst_fw_wr", {31'd0, wb_fw_writereg}, 32'd1);

    @(negedge clock);
    chk("rst_hold_en", {31'd0, wb_reg_en}, 32'd0);
    chk("rst_hold_data", wb_reg_data, 32'd0);
    reset = 1'b0;
    drive(5'd2, 1'b1, 32'hFFFFA0EE, 1'b1);

    @(negedge clock);
    drive(5'd30, 1'b0, 32'h5538A0AB, 1'b0);

    @(negedge clock);
    drive(5'd8, 1'b1, 32'h07E8A0EE, 1'b1);
    // Previous capture must still be visible before the edge.
    chk("hold_en", {31'd0, wb_reg_en}, 32'd0);
    chk("hold_addr", {27'd0, wb_reg_addr}, 32'd30);
    chk("hold_data", wb_reg_data, 32'h5538A0AB);

    // Mid-run reset while en=1, addr=8.
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_rst_en", {31'd0, wb_reg_en}, 32'd0);
    chk("mid_rst_addr", {27'd0, wb_reg_addr}, 32'd0);
    chk("mid_rst_data", wb_reg_data, 32'd0);

    @(negedge clock);
    mem_wb_regdest = 5'd17;
    mem_wb_writereg = 1'b1;
    mem_wb_wbvalue = 32'h12345678;
    #1;
    chk("mid_rst_fw_val", wb_fw_wbvalue, 32'h12345678);
    chk("mid_rst_fw_wr", {31'd0, wb_fw_writereg}, 32'd1);
    @(posedge clock);
    #1;
    chk("mid_rst_edge_en", {31'd0, wb_reg_en}, 32'd0);
    chk("mid_rst_edge_data", wb_reg_data, 32'd0);

    // Release: the next edge captures the inputs already present.
    @(negedge clock);
    reset = 1'b0;
    drive(5'd17, 1'b1, 32'h12345678, 1'b1);

    @(negedge clock);
    drive(5'd0, 1'b1, 32'hDEADBEEF, zero_en_req);

    @(negedge clock);
    drive(5'd31, 1'b1, 32'h00000000, 1'b1);

    @(negedge clock);
    drive(5'd1, 1'b0, 32'h80000000, 1'b0);

    @(negedge clock);
    drive(5'd0, 1'b0, 32'h0000FFFF, 1'b0);

    // Idle cycle with held inputs is still a capture.
    @(negedge clock);
    drive(5'd0, 1'b0, 32'h0000FFFF, 1'b0);

    repeat (3) @(negedge clock);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/writeback.md
# writeback

Final (WB) stage of the five-stage pipelined processor. It takes the destination register, write-enable and result value from the MEM/WB pipeline latch, presents them, registered, to the register-file write port, and mirrors them combinationally to the forwarding unit. There is no arithmetic; the block is a timed, gated pass-through.

## Interface
Parameters:
- DATA_W, 32, width of the write-back value.
- ADDR_W, 5, width of the register address (32 architectural registers).

Ports (reset reset, asynchronous, active-high; clock clock):
- clock  in  1  pipeline clock; rising edge is the active edge.
- reset  in  1  asynchronous, active-high reset.
- mem_wb_regdest  in  ADDR_W  destination register index from MEM/WB.
- mem_wb_writereg  in  1  instruction writes a register.
- mem_wb_wbvalue  in  DATA_W  result to write back (ALU or load data, already selected upstream).
- wb_reg_en  out  1  register-file write enable (registered).
- wb_reg_addr  out  ADDR_W  register-file write address (registered).
- wb_reg_data  out  DATA_W  register-file write data (registered).
- wb_fw_wbvalue  out  DATA_W  value sent to forwarding (combinational).
- wb_fw_writereg  out  1  write-valid flag sent to forwarding (combinational).

## Operation
- On every rising clock edge when reset is low, latch: wb_reg_en <= mem_wb_writereg; wb_reg_addr <= mem_wb_regdest; wb_reg_data <= mem_wb_wbvalue.
- Address and data are latched unconditionally, and only wb_reg_en qualifies the write. With mem_wb_writereg=0, addr and data still update and en=0.
- Forwarding path is purely combinational: wb_fw_wbvalue = mem_wb_wbvalue; wb_fw_writereg = mem_wb_writereg (subject to Configuration). It is not affected by reset.
- No state machine. The single register stage is the only state.

## Timing
- Reset assertion immediately, asynchronously forces wb_reg_en=0, wb_reg_addr=0, wb_reg_data=0. These values are held while reset is high.
- First capture occurs on the first rising edge after reset deasserts.
- Register-port latency is 1 cycle. Inputs stable before posedge N appear on wb_reg_* after posedge N and are held until posedge N+1.
- Forwarding latency is 0 cycles. wb_fw_* follow input changes within the same cycle, with no clock dependence.
- If reset asserts mid-operation, the pending write is dropped (en=0). Forwarding outputs keep following the inputs.
- Inputs change on the falling edge in the system, giving half a cycle of setup. No handshake and no stall input exist.

## Configuration
- Macro WB_ZERO_REG_GUARD_EN.
- Defined: a write to register 0 is suppressed. When mem_wb_regdest==0, the latched wb_reg_en becomes 0 and wb_fw_writereg becomes 0. Addr and data still pass through.
- Undefined: no special case for register 0. The enable follows mem_wb_writereg exactly, and the register file is responsible for hard-wiring r0.

## Structure
- Shared package (pipeline_pkg) holds DATA_W=32, ADDR_W=5, REG_ZERO=0, and the reset constants for en, addr and data.
- One natural sub-module, wb_pipe_reg: a parameterised asynchronous-reset register. It is instantiated for the {en, addr, data} bundle.
- Forwarding assigns and the zero-register guard live in the top level.

## Test plan
- Reset: assert reset at any time -> wb_reg_en=0, wb_reg_addr=0, wb_reg_data=0 at once, with no clock edge needed.
- Write r2: regdest=2, writereg=1, wbvalue=FFFFA0EE. Forwarding shows FFFFA0EE/1 before the edge. After the next posedge: en=1, addr=2, data=FFFFA0EE.
- Non-write: regdest=30, writereg=0, wbvalue=5538A0AB. Forwarding shows 5538A0AB/0. After posedge: en=0, addr=30, data=5538A0AB.
- Write r8: regdest=8, writereg=1, wbvalue=07E8A0EE. After posedge: en=1, addr=8, data=07E8A0EE. Previous values are held until that edge.
- Mid-run reset: assert reset while en=1, addr=8 -> outputs clear immediately. After release, the next posedge captures the current inputs.
- With WB_ZERO_REG_GUARD_EN: regdest=0, writereg=1, wbvalue=DEADBEEF -> wb_fw_writereg=0. After posedge: en=0, addr=0, data=DEADBEEF. Without the macro: en=1.
